// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from a variable-latency
// instruction memory, holds the word for the core and resolves the next PC.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            instr_ack,
  input  logic            jal,
  input  logic            jalr,
  input  logic            branch,
  input  logic            zero,
  input  logic            neg,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic [31:0]     instret
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     instret_q, instret_d;

  logic [2:0]      func3;
  logic            cond;
  logic            taken;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic            unused_alu_lsb;

  assign unused_alu_lsb = alu_result[0];

  assign func3  = instr_q[14:12];
  assign seq_pc = pc_q + PC_STEP;

  always_comb begin
    cond = 1'b0;
    case (func3)
      3'b000:  cond = zero;
      3'b001:  cond = ~zero;
      3'b100:  cond = neg;
      3'b101:  cond = ~neg;
      default: cond = 1'b0;
    endcase
  end

  assign taken = branch & cond;

  // jalr outranks jal; a branch qualified alongside jal still lands on pc+imm.
  always_comb begin
    next_pc = seq_pc;
    if (jalr) begin
      next_pc = {alu_result[XLEN-1:1], 1'b0};
    end else if (jal || taken) begin
      next_pc = pc_q + imm;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (instr_ack) begin
          pc_d      = next_pc;
          instret_d = instret_q + 32'd1;
          state_d   = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

  // Request/valid decode straight from the state flop so reset drops them at once.
  assign imem_req    = (state_q == S_REQ);
  assign instr_valid = (state_q == S_VALID);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign pc_plus4    = seq_pc;
  assign instr       = instr_q;
  assign instret     = instret_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the main controller.
- Owns the PC and issues requests to a variable-latency instruction memory.
- Holds the fetched instruction stable while the core executes it, then accepts the core's jal/jalr/branch/zero/neg verdict to pick the next PC.
- Also keeps a retired-instruction counter for debug/perf.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  XLEN  fetch address; equals pc while imem_req=1.
- imem_ready  in  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- instr_valid  out  1  instr/pc hold a fetched instruction for the core.
- instr  out  32  registered instruction; core slices op [6:0], func3 [14:12], func7 [31:25].
- pc  out  XLEN  address of instr.
- pc_plus4  out  XLEN  pc+4, used as the link value for jal/jalr.
- instr_ack  in  1  core has finished instr this cycle; next-PC inputs are valid.
- jal  in  1  from controller.
- jalr  in  1  from controller.
- branch  in  1  from controller.
- zero  in  1  ALU zero flag.
- neg  in  1  ALU negative flag.
- imm  in  XLEN  sign-extended immediate.
- alu_result  in  XLEN  jalr target (rs1+imm).
- instret  out  32  count of acknowledged instructions.

Behaviour:
- Reset (async, rst_n=0): state=S_IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, instret=0. Outputs take these values immediately. A fetch in flight is abandoned; an imem_ready arriving during reset is ignored.
- FSM, 3 states:
  - S_IDLE: one cycle after reset release, then unconditionally to S_REQ.
  - S_REQ: imem_req=1, imem_addr=pc. On imem_ready=1: instr<=imem_rdata, next state S_VALID. Otherwise hold, with no timeout.
  - S_VALID: instr_valid=1, imem_req=0, and instr/pc are held constant. On instr_ack=1: pc<=next_pc, instret<=instret+1 (wraps 32'hFFFF_FFFF->0), next state S_REQ. Otherwise hold.
- instr_ack outside S_VALID is ignored and does not affect pc or instret.
- Fetch-to-valid latency: instr_valid rises the cycle after imem_ready is sampled high. With imem_ready tied high, each instruction takes at least 2 cycles (S_REQ then S_VALID).
- Branch condition uses instr[14:12]:
  - 000 taken if zero.
  - 001 taken if !zero.
  - 100 taken if neg.
  - 101 taken if !neg.
  - All other encodings are not taken.
  - taken = branch & cond.
- next_pc priority:
  - jalr -> {alu_result[XLEN-1:1],1'b0}.
  - else jal | taken -> pc+imm.
  - else pc+4.
  - Additions are modulo 2^XLEN; wrap-around is legal.
- Simultaneous jal and jalr: jalr wins. branch with jal is treated as jal.
- pc_plus4 is combinational from pc and is valid in every state.
- Misaligned targets: bit 0 is cleared only for jalr. No exception is raised.

Test Plan:
- Reset/first fetch: rst_n low then high, imem_ready=1 -> imem_req rises one cycle after release with imem_addr=0; instr_valid=1 the next cycle, instr=imem_rdata.
- Sequential: ack with jal=jalr=branch=0 at pc=0x10 -> next imem_addr=0x14, instret increments by 1.
- Branch: instr func3=000, branch=1, zero=1, imm=-8 at pc=0x20 -> next pc=0x18. Same with zero=0 -> next pc=0x24. func3=101, neg=0 -> taken.
- Jumps: jal=1, imm=0x100 at pc=0x40 -> next pc=0x140, pc_plus4=0x44 during S_VALID. jalr=1, jal=1, alu_result=0x203 -> next pc=0x202.
- Memory stall and hold: imem_ready low for 5 cycles -> imem_req stays high with a stable address and instr_valid=0. With instr_ack held low for 4 cycles in S_VALID, instr and pc remain unchanged and instret does not change.
- Async reset mid-fetch and wrap: assert rst_n in S_REQ -> imem_req drops without a clock edge and pc=RESET_PC. With pc=0xFFFF_FFFC sequential -> next pc=0x0. Preload instret=0xFFFF_FFFF, ack -> 0.
